// File: rtl/stage_mem.sv
// MEM stage: data-cache access FSM and MEM/WB register.
// Define LLSC_EN to add the load-linked / store-conditional link register.
module stage_mem (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ex_valid,
  input  logic [31:0] ex_aluOut,
  input  logic [31:0] ex_storeData,
  input  logic [31:0] ex_npc,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic        ex_memtoReg,
  input  logic        ex_regWrite,
  input  logic        ex_jal,
  input  logic [4:0]  ex_regSel,
  input  logic        ex_ll,
  input  logic        ex_sc,
  input  logic        flush,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_memtoReg,
  output logic        wb_regWrite,
  output logic        wb_jal,
  output logic [4:0]  wb_regSel,
  output logic [31:0] wb_aluOut,
  output logic [31:0] wb_dmemload,
  output logic [31:0] wb_npc
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nx;

  logic        sc_req, sc_pass, ll_req;
  logic        is_rd, is_wr, accept, go_mem, done;

  logic [31:0] req_addr, req_data, req_npc;
  logic        req_rd, req_wr, req_memtoReg;
  logic        req_regWrite, req_jal, req_ll, req_sc;
  logic [4:0]  req_regSel;

`ifdef LLSC_EN
  logic        link_v;
  logic [31:0] link_a;

  assign sc_req  = ex_sc;
  assign ll_req  = ex_ll;
  assign sc_pass = link_v && (link_a == ex_aluOut);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      link_v <= 1'b0;
      link_a <= '0;
    end else if (done) begin
      if (req_ll) begin
        link_v <= 1'b1;
        link_a <= req_addr;
      end else if (req_wr && link_a == req_addr) begin
        link_v <= 1'b0;
      end
    end
  end
`else
  logic unused_llsc;

  assign unused_llsc = ex_ll ^ ex_sc;
  assign sc_req  = 1'b0;
  assign ll_req  = 1'b0;
  assign sc_pass = 1'b0;
`endif

  // A failed sc skips memory and retires like an ALU op.
  assign is_wr  = sc_req ? sc_pass : ex_memWrite;
  assign is_rd  = !sc_req && (ex_memRead || ll_req);
  assign accept = (state == IDLE) && ex_valid && !flush;
  assign go_mem = accept && (is_rd || is_wr);
  assign done   = (state == BUSY) && dhit;

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go_mem) state_nx = BUSY;
      BUSY: if (dhit)   state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  always_comb begin
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    mem_stall = 1'b0;
    if (state == BUSY) begin
      dREN      = req_rd;
      dWEN      = req_wr;
      daddr     = req_addr;
      dstore    = req_data;
      mem_stall = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      req_addr     <= '0;
      req_data     <= '0;
      req_npc      <= '0;
      req_rd       <= 1'b0;
      req_wr       <= 1'b0;
      req_memtoReg <= 1'b0;
      req_regWrite <= 1'b0;
      req_jal      <= 1'b0;
      req_ll       <= 1'b0;
      req_sc       <= 1'b0;
      req_regSel   <= '0;
    end else if (go_mem) begin
      req_addr     <= ex_aluOut;
      req_data     <= ex_storeData;
      req_npc      <= ex_npc;
      req_rd       <= is_rd && !is_wr;
      req_wr       <= is_wr;
      req_memtoReg <= ex_memtoReg && !sc_req;
      req_regWrite <= ex_regWrite;
      req_jal      <= ex_jal;
      req_ll       <= ll_req && !is_wr;
      req_sc       <= sc_req;
      req_regSel   <= ex_regSel;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wb_valid    <= 1'b0;
      wb_memtoReg <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_jal      <= 1'b0;
      wb_regSel   <= '0;
      wb_aluOut   <= '0;
      wb_dmemload <= '0;
      wb_npc      <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (done) begin
        wb_valid    <= 1'b1;
        wb_memtoReg <= req_memtoReg;
        wb_regWrite <= req_regWrite;
        wb_jal      <= req_jal;
        wb_regSel   <= req_regSel;
        wb_aluOut   <= req_sc ? 32'd1 : req_addr;
        wb_dmemload <= req_rd ? dmemload : '0;
        wb_npc      <= req_npc;
      end else if (accept && !go_mem) begin
        wb_valid    <= 1'b1;
        wb_memtoReg <= ex_memtoReg && !sc_req;
        wb_regWrite <= ex_regWrite;
        wb_jal      <= ex_jal;
        wb_regSel   <= ex_regSel;
        wb_aluOut   <= sc_req ? '0 : ex_aluOut;
        wb_dmemload <= '0;
        wb_npc      <= ex_npc;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: ALU pass-through, loads, stores,
// flush, reset mid-access and (when LLSC_EN is defined) ll/sc.
module tb_stage_mem;

  logic        CLK, nRST;
  logic        ex_valid;
  logic [31:0] ex_aluOut, ex_storeData, ex_npc;
  logic        ex_memRead, ex_memWrite, ex_memtoReg;
  logic        ex_regWrite, ex_jal;
  logic [4:0]  ex_regSel;
  logic        ex_ll, ex_sc, flush, dhit;
  logic [31:0] dmemload;
  logic        dREN, dWEN, mem_stall;
  logic [31:0] daddr, dstore;
  logic        wb_valid, wb_memtoReg, wb_regWrite, wb_jal;
  logic [4:0]  wb_regSel;
  logic [31:0] wb_aluOut, wb_dmemload, wb_npc;

  int n_chk = 0;
  int n_fail = 0;

  stage_mem dut (
    .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid),
    .ex_aluOut(ex_aluOut), .ex_storeData(ex_storeData),
    .ex_npc(ex_npc), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_memtoReg(ex_memtoReg),
    .ex_regWrite(ex_regWrite), .ex_jal(ex_jal),
    .ex_regSel(ex_regSel), .ex_ll(ex_ll), .ex_sc(ex_sc),
    .flush(flush), .dhit(dhit), .dmemload(dmemload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_memtoReg(wb_memtoReg), .wb_regWrite(wb_regWrite),
    .wb_jal(wb_jal), .wb_regSel(wb_regSel),
    .wb_aluOut(wb_aluOut), .wb_dmemload(wb_dmemload),
    .wb_npc(wb_npc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic rd, input logic wr,
                        input logic ll, input logic sc,
                        input logic [31:0] a, input logic [31:0] d);
    ex_valid     = v;
    ex_memRead   = rd;
    ex_memWrite  = wr;
    ex_ll        = ll;
    ex_sc        = sc;
    ex_aluOut    = a;
    ex_storeData = d;
    ex_npc       = a + 32'd4;
    ex_memtoReg  = rd;
    ex_regWrite  = 1'b1;
    ex_jal       = 1'b0;
    ex_regSel    = 5'd7;
  endtask

  task automatic clr_ex();
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    ex_regWrite = 1'b0;
    ex_regSel   = '0;
  endtask

  // Issue a memory op, complete it on the first BUSY cycle.
  task automatic quick_mem(input logic rd, input logic wr,
                           input logic ll, input logic sc,
                           input logic [31:0] a, input logic [31:0] d);
    set_ex(1'b1, rd, wr, ll, sc, a, d);
    tick();
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    clr_ex();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    clr_ex();
    flush = 1'b0;
    dhit = 1'b0;
    dmemload = '0;
    tick();
    tick();
    nRST = 1'b1;
    n_chk++; if (dREN !== 1'b0) begin n_fail++; $display("FAIL rst_dREN: got %b want 0", dREN); end
    n_chk++; if (dWEN !== 1'b0) begin n_fail++; $display("FAIL rst_dWEN: got %b want 0", dWEN); end
    n_chk++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", wb_valid); end
    n_chk++; if (daddr !== 32'h0) begin n_fail++; $display("FAIL rst_daddr: got %h want 0", daddr); end
  endtask

  task automatic test_alu();
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    ex_regSel = 5'd3;
    tick();
    clr_ex();
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b want 1", wb_valid); end
    n_chk++; if (wb_aluOut !== 32'h10) begin n_fail++; $display("FAIL alu_out: got %h want 10", wb_aluOut); end
    n_chk++; if (wb_regSel !== 5'd3) begin n_fail++; $display("FAIL alu_regSel: got %0d want 3", wb_regSel); end
    n_chk++; if (wb_regWrite !== 1'b1) begin n_fail++; $display("FAIL alu_regWrite: got %b want 1", wb_regWrite); end
    n_chk++; if (wb_npc !== 32'h14) begin n_fail++; $display("FAIL alu_npc: got %h want 14", wb_npc); end
    n_chk++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", mem_stall); end
    tick();
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_bubble: got %b want 0", wb_valid); end
  endtask

  task automatic test_load();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
    tick();
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_accept_valid: got %b want 0", wb_valid); end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        dhit = 1'b1;
        dmemload = 32'hDEADBEEF;
      end
      n_chk++; if (dREN !== 1'b1) begin n_fail++; $display("FAIL ld_dREN[%0d]: got %b want 1", i, dREN); end
      n_chk++; if (dWEN !== 1'b0) begin n_fail++; $display("FAIL ld_dWEN[%0d]: got %b want 0", i, dWEN); end
      n_chk++; if (daddr !== 32'h40) begin n_fail++; $display("FAIL ld_daddr[%0d]: got %h want 40", i, daddr); end
      n_chk++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall[%0d]: got %b want 1", i, mem_stall); end
      n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_bubble[%0d]: got %b want 0", i, wb_valid); end
      tick();
    end
    dhit = 1'b0;
    dmemload = '0;
    clr_ex();
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL ld_valid: got %b want 1", wb_valid); end
    n_chk++; if (wb_dmemload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_data: got %h want deadbeef", wb_dmemload); end
    n_chk++; if (wb_aluOut !== 32'h40) begin n_fail++; $display("FAIL ld_alu: got %h want 40", wb_aluOut); end
    n_chk++; if (wb_memtoReg !== 1'b1) begin n_fail++; $display("FAIL ld_memtoReg: got %b want 1", wb_memtoReg); end
    n_chk++; if (wb_regSel !== 5'd7) begin n_fail++; $display("FAIL ld_regSel: got %0d want 7", wb_regSel); end
    n_chk++; if (wb_npc !== 32'h44) begin n_fail++; $display("FAIL ld_npc: got %h want 44", wb_npc); end
    n_chk++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL ld_idle_stall: got %b want 0", mem_stall); end
    n_chk++; if (dREN !== 1'b0) begin n_fail++; $display("FAIL ld_idle_dREN: got %b want 0", dREN); end
  endtask

  task automatic test_store();
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h1234);
    tick();
    dhit = 1'b1;
    n_chk++; if (dWEN !== 1'b1) begin n_fail++; $display("FAIL st_dWEN: got %b want 1", dWEN); end
    n_chk++; if (dREN !== 1'b0) begin n_fail++; $display("FAIL st_dREN: got %b want 0", dREN); end
    n_chk++; if (dstore !== 32'h1234) begin n_fail++; $display("FAIL st_dstore: got %h want 1234", dstore); end
    n_chk++; if (daddr !== 32'h80) begin n_fail++; $display("FAIL st_daddr: got %h want 80", daddr); end
    n_chk++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL st_stall: got %b want 1", mem_stall); end
    tick();
    dhit = 1'b0;
    clr_ex();
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid: got %b want 1", wb_valid); end
    n_chk++; if (wb_aluOut !== 32'h80) begin n_fail++; $display("FAIL st_alu: got %h want 80", wb_aluOut); end
    n_chk++; if (dWEN !== 1'b0) begin n_fail++; $display("FAIL st_idle_dWEN: got %b want 0", dWEN); end
    n_chk++; if (dstore !== 32'h0) begin n_fail++; $display("FAIL st_idle_dstore: got %h want 0", dstore); end
    n_chk++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL st_idle_stall: got %b want 0", mem_stall); end
  endtask

  task automatic test_rw_both();
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC0, 32'h55);
    tick();
    n_chk++; if (dWEN !== 1'b1) begin n_fail++; $display("FAIL rw_dWEN: got %b want 1", dWEN); end
    n_chk++; if (dREN !== 1'b0) begin n_fail++; $display("FAIL rw_dREN: got %b want 0", dREN); end
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    clr_ex();
  endtask

  task automatic test_flush();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0);
    flush = 1'b1;
    tick();
    n_chk++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall: got %b want 0", mem_stall); end
    n_chk++; if (dREN !== 1'b0) begin n_fail++; $display("FAIL fl_dREN: got %b want 0", dREN); end
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", wb_valid); end
    flush = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    n_chk++; if (dREN !== 1'b1) begin n_fail++; $display("FAIL fl_busy_dREN: got %b want 1", dREN); end
    n_chk++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL fl_busy_stall: got %b want 1", mem_stall); end
    dhit = 1'b1;
    dmemload = 32'hA5A5;
    tick();
    dhit = 1'b0;
    flush = 1'b0;
    clr_ex();
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL fl_busy_done: got %b want 1", wb_valid); end
    n_chk++; if (wb_dmemload !== 32'hA5A5) begin n_fail++; $display("FAIL fl_busy_data: got %h want a5a5", wb_dmemload); end
  endtask

  task automatic test_reset_busy();
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
    tick();
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    clr_ex();
    n_chk++; if (dREN !== 1'b0) begin n_fail++; $display("FAIL rb_dREN: got %b want 0", dREN); end
    n_chk++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rb_stall: got %b want 0", mem_stall); end
    n_chk++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rb_valid: got %b want 0", wb_valid); end
    n_chk++; if (wb_aluOut !== 32'h0) begin n_fail++; $display("FAIL rb_alu: got %h want 0", wb_aluOut); end
    n_chk++; if (wb_dmemload !== 32'h0) begin n_fail++; $display("FAIL rb_data: got %h want 0", wb_dmemload); end
    n_chk++; if (wb_npc !== 32'h0) begin n_fail++; $display("FAIL rb_npc: got %h want 0", wb_npc); end
    n_chk++; if (wb_regSel !== 5'd0) begin n_fail++; $display("FAIL rb_regSel: got %0d want 0", wb_regSel); end
    n_chk++; if (wb_regWrite !== 1'b0) begin n_fail++; $display("FAIL rb_regWrite: got %b want 0", wb_regWrite); end
    n_chk++; if (wb_memtoReg !== 1'b0) begin n_fail++; $display("FAIL rb_memtoReg: got %b want 0", wb_memtoReg); end
    tick();
    n_chk++; if (dREN !== 1'b0) begin n_fail++; $display("FAIL rb_idle_dREN: got %b want 0", dREN); end
  endtask

  task automatic test_back_to_back();
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h11, 32'h0);
    tick();
    n_chk++; if (wb_aluOut !== 32'h11) begin n_fail++; $display("FAIL b2b_first: got %h want 11", wb_aluOut); end
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22, 32'h0);
    ex_jal = 1'b1;
    tick();
    clr_ex();
    n_chk++; if (wb_aluOut !== 32'h22) begin n_fail++; $display("FAIL b2b_second: got %h want 22", wb_aluOut); end
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", wb_valid); end
    n_chk++; if (wb_jal !== 1'b1) begin n_fail++; $display("FAIL b2b_jal: got %b want 1", wb_jal); end
    tick();
  endtask

`ifdef LLSC_EN
  task automatic test_llsc();
    quick_mem(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h77);
    tick();
    n_chk++; if (dWEN !== 1'b1) begin n_fail++; $display("FAIL sc_ok_dWEN: got %b want 1", dWEN); end
    n_chk++; if (dstore !== 32'h77) begin n_fail++; $display("FAIL sc_ok_dstore: got %h want 77", dstore); end
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    clr_ex();
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL sc_ok_valid: got %b want 1", wb_valid); end
    n_chk++; if (wb_aluOut !== 32'h1) begin n_fail++; $display("FAIL sc_ok_result: got %h want 1", wb_aluOut); end
    quick_mem(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    quick_mem(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h9);
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h88);
    tick();
    clr_ex();
    n_chk++; if (dWEN !== 1'b0) begin n_fail++; $display("FAIL sc_bad_dWEN: got %b want 0", dWEN); end
    n_chk++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL sc_bad_stall: got %b want 0", mem_stall); end
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL sc_bad_valid: got %b want 1", wb_valid); end
    n_chk++; if (wb_aluOut !== 32'h0) begin n_fail++; $display("FAIL sc_bad_result: got %h want 0", wb_aluOut); end
    n_chk++; if (wb_regWrite !== 1'b1) begin n_fail++; $display("FAIL sc_bad_regWrite: got %b want 1", wb_regWrite); end
    tick();
  endtask
`else
  task automatic test_llsc();
    set_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    n_chk++; if (dREN !== 1'b1) begin n_fail++; $display("FAIL ll_plain_dREN: got %b want 1", dREN); end
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h77);
    tick();
    n_chk++; if (dWEN !== 1'b1) begin n_fail++; $display("FAIL sc_plain_dWEN: got %b want 1", dWEN); end
    n_chk++; if (dstore !== 32'h77) begin n_fail++; $display("FAIL sc_plain_dstore: got %h want 77", dstore); end
    dhit = 1'b1;
    tick();
    dhit = 1'b0;
    clr_ex();
    n_chk++; if (wb_aluOut !== 32'h100) begin n_fail++; $display("FAIL sc_plain_alu: got %h want 100", wb_aluOut); end
    n_chk++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL sc_plain_valid: got %b want 1", wb_valid); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_rw_both();
    test_flush();
    test_reset_busy();
    test_back_to_back();
    test_llsc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
